// File: rtl/fpu_pkg.sv
// Shared fp32 constants, field layout and operand classification.
package fpu_pkg;

    localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
    localparam logic [31:0] FP32_POS_INF = 32'h7F800000;
    localparam logic [31:0] FP32_NEG_INF = 32'hFF800000;
    localparam logic [31:0] FP32_ONE     = 32'h3F800000;
    localparam logic [7:0]  FP32_BIAS    = 8'd127;
    localparam logic [31:0] FP32_LN2     = 32'h3F317218;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {ZERO, DENORM, NORMAL, INF, NAN} fp_class_t;

    function automatic fp_class_t classify(input fp32_t x);
        if (x.exp == 8'hFF) begin
            return (x.frac != 23'd0) ? NAN : INF;
        end else if (x.exp == 8'h00) begin
            return (x.frac != 23'd0) ? DENORM : ZERO;
        end
        return NORMAL;
    endfunction

endpackage

// File: rtl/lzc23.sv
// Combinational leading-zero counter over 23 bits; an all-zero input yields 23.
module lzc23 (
    input  logic [22:0] din,
    output logic [4:0]  cnt
);

    always_comb begin
        cnt = 5'd23;
        // Highest set bit is visited last and therefore wins.
        for (int i = 0; i < 23; i++) begin
            if (din[i]) begin
                cnt = 5'(22 - i);
            end
        end
    end

endmodule

// File: rtl/fln_argred.sv
// Two-stage argument reduction for ln(x): x = m * 2^e with m in [0.75, 1.5),
// e also delivered as an exact fp32, IEEE specials resolved and flagged.
module fln_argred
    import fpu_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_mant,
    output logic [8:0]       out_exp_i,
    output logic [31:0]      out_exp_f,
    output logic             out_special,
    output logic [31:0]      out_spec_val,
    output logic [TAG_W-1:0] out_tag
);

    fp32_t     x;
    fp_class_t cls;
    logic [4:0]  dz;
    logic [8:0]  e0;
    logic [22:0] frac;
    logic [31:0] mant_d;
    logic [8:0]  exp_d;
    logic        special_d;
    logic [31:0] spec_val_d;

    logic             s1_valid;
    logic [31:0]      s1_mant;
    logic [8:0]       s1_exp;
    logic             s1_special;
    logic [31:0]      s1_spec_val;
    logic [TAG_W-1:0] s1_tag;

    logic        s2_adv;
    logic        e_neg;
    logic [7:0]  e_mag;
    logic [4:0]  e_lz;
    logic [22:0] e_frac;
    logic [31:0] exp_f_d;

    assign x   = in_data;
    assign cls = classify(x);

    lzc23 u_lzc_denorm (
        .din (x.frac),
        .cnt (dz)
    );

    always_comb begin
        special_d  = 1'b1;
        spec_val_d = FP32_QNAN;
        mant_d     = FP32_ONE;
        exp_d      = 9'd0;
        e0         = 9'd0;
        frac       = 23'd0;
        unique case (cls)
            NAN:  spec_val_d = FP32_QNAN;
            ZERO: spec_val_d = FP32_NEG_INF;
            INF:  spec_val_d = x.sign ? FP32_QNAN : FP32_POS_INF;
            default: begin
                if (!x.sign) begin
                    special_d  = 1'b0;
                    spec_val_d = 32'd0;
                    if (cls == NORMAL) begin
                        e0   = {1'b0, x.exp} - {1'b0, FP32_BIAS};
                        frac = x.frac;
                    end else begin
                        // Shift the leading one out of the field; it becomes the hidden bit.
                        e0   = 9'd0 - {1'b0, FP32_BIAS} - {4'd0, dz};
                        frac = x.frac << (dz + 5'd1);
                    end
                    // Mantissas in [1.5, 2) are halved into [0.75, 1).
                    if (frac[22]) begin
                        mant_d = {1'b0, FP32_BIAS - 8'd1, frac};
                        exp_d  = e0 + 9'd1;
                    end else begin
                        mant_d = {1'b0, FP32_BIAS, frac};
                        exp_d  = e0;
                    end
                end
            end
        endcase
    end

    // |e| <= 149 fits in 8 bits; left-align it so the 23-bit counter can be reused.
    assign e_neg = s1_exp[8];
    assign e_mag = e_neg ? (8'd0 - s1_exp[7:0]) : s1_exp[7:0];

    lzc23 u_lzc_int (
        .din ({e_mag, 15'd0}),
        .cnt (e_lz)
    );

    assign e_frac  = {e_mag, 15'd0} << (e_lz + 5'd1);
    assign exp_f_d = (e_mag == 8'd0) ? 32'd0
                   : {e_neg, FP32_BIAS + 8'd7 - {3'd0, e_lz}, e_frac};

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !rst && (!s1_valid || s2_adv);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_mant      <= 32'd0;
            s1_exp       <= 9'd0;
            s1_special   <= 1'b0;
            s1_spec_val  <= 32'd0;
            s1_tag       <= '0;
            out_valid    <= 1'b0;
            out_mant     <= 32'd0;
            out_exp_i    <= 9'd0;
            out_exp_f    <= 32'd0;
            out_special  <= 1'b0;
            out_spec_val <= 32'd0;
            out_tag      <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_mant     <= mant_d;
                    s1_exp      <= exp_d;
                    s1_special  <= special_d;
                    s1_spec_val <= spec_val_d;
                    s1_tag      <= in_tag;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_mant     <= s1_mant;
                    out_exp_i    <= s1_exp;
                    out_exp_f    <= exp_f_d;
                    out_special  <= s1_special;
                    out_spec_val <= s1_spec_val;
                    out_tag      <= s1_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_fln_argred.sv
// Self-checking bench for fln_argred: directed vectors, backpressure, random throughput, reset.
module tb_fln_argred;

    typedef struct packed {
        logic [31:0] mant;
        logic [8:0]  e;
        logic [31:0] ef;
        logic        sp;
        logic [31:0] sv;
        logic [3:0]  tag;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic [3:0]  in_tag = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_mant;
    logic [8:0]  out_exp_i;
    logic [31:0] out_exp_f;
    logic        out_special;
    logic [31:0] out_spec_val;
    logic [3:0]  out_tag;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fln_argred #(.TAG_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_mant     (out_mant),
        .out_exp_i    (out_exp_i),
        .out_exp_f    (out_exp_f),
        .out_special  (out_special),
        .out_spec_val (out_spec_val),
        .out_tag      (out_tag)
    );

    function automatic real scale2(input real v, input int k);
        real r = v;
        if (k > 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else       for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    // Value of a positive finite fp32 as a double (always exact).
    function automatic real xval(input logic [31:0] x);
        int ex = int'(x[30:23]);
        if (ex == 0) return scale2(real'(x[22:0]), -149);
        return scale2(real'({1'b1, x[22:0]}), ex - 150);
    endfunction

    // Reference: find m in [0.75,1.5) by repeated halving/doubling of the real value.
    function automatic res_t model(input logic [31:0] x, input logic [3:0] tag);
        res_t        r;
        real         m;
        int          e;
        logic [63:0] db;
        logic [10:0] de;
        logic [7:0]  ex8;
        r = '0;
        r.tag = tag;
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) begin r.sp = 1'b1; r.sv = 32'h7FC00000; end
        else if (x[30:0] == 31'd0)                 begin r.sp = 1'b1; r.sv = 32'hFF800000; end
        else if (x[31])                            begin r.sp = 1'b1; r.sv = 32'h7FC00000; end
        else if (x[30:23] == 8'hFF)                begin r.sp = 1'b1; r.sv = 32'h7F800000; end
        if (r.sp) begin
            r.mant = 32'h3F800000;
            return r;
        end
        m = xval(x);
        e = 0;
        while (m >= 1.5)  begin m = m / 2.0; e++; end
        while (m < 0.75) begin m = m * 2.0; e--; end
        if (m >= 1.0) begin
            r.mant[31:23] = {1'b0, 8'd127};
            r.mant[22:0]  = 23'($rtoi((m - 1.0) * 8388608.0));
        end else begin
            r.mant[31:23] = {1'b0, 8'd126};
            r.mant[22:0]  = 23'($rtoi((m * 2.0 - 1.0) * 8388608.0));
        end
        r.e = 9'(e);
        if (e != 0) begin
            db  = $realtobits(real'(e));
            de  = db[62:52];
            ex8 = 8'(int'(de) - 896);
            r.ef = {db[63], ex8, db[51:29]};
        end
        return r;
    endfunction

    // Drive one cycle: set inputs at edge+1, sample at edge+2, return at next edge+1.
    task automatic step(input logic v, input logic [31:0] d, input logic [3:0] t,
                        input logic ordy, output logic acc, output logic ov, output res_t g);
        in_valid  = v;
        in_data   = d;
        in_tag    = t;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        ov  = out_valid;
        g   = {out_mant, out_exp_i, out_exp_f, out_special, out_spec_val, out_tag};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b00)
            $display("FAIL reset_handshake: got valid/ready=%b%b, expected 00", out_valid, in_ready);
        checks++;
        if ({out_mant, out_exp_i, out_exp_f, out_special, out_spec_val, out_tag} !== '0)
            $display("FAIL reset_data: got mant=%h e=%h ef=%h sp=%b sv=%h tag=%h, expected all 0",
                     out_mant, out_exp_i, out_exp_f, out_special, out_spec_val, out_tag);
        if ({out_valid, in_ready} !== 2'b00 ||
            {out_mant, out_exp_i, out_exp_f, out_special, out_spec_val, out_tag} !== '0)
            errors += (({out_valid, in_ready} !== 2'b00) ? 1 : 0) +
                      (({out_mant, out_exp_i, out_exp_f, out_special, out_spec_val, out_tag} !== '0)
                       ? 1 : 0);
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] xv [14];
        res_t        ev [14];
        logic        acc, ov;
        res_t        g;
        int          sent = 0, got = 0, cyc = 0;
        xv = '{32'h3F800000, 32'h40400000, 32'h3F000000, 32'h00000001, 32'h7F7FFFFF,
               32'h00000000, 32'h80000000, 32'hC0000000, 32'h7FC00001, 32'h7F800000,
               32'hFF800000, 32'h3FC00000, 32'h00400000, 32'h00600000};
        ev[0]  = '{32'h3F800000, 9'h000, 32'h00000000, 1'b0, 32'h0, 4'd0};
        ev[1]  = '{32'h3F400000, 9'h002, 32'h40000000, 1'b0, 32'h0, 4'd0};
        ev[2]  = '{32'h3F800000, 9'h1FF, 32'hBF800000, 1'b0, 32'h0, 4'd0};
        ev[3]  = '{32'h3F800000, 9'h16B, 32'hC3150000, 1'b0, 32'h0, 4'd0};
        ev[4]  = '{32'h3F7FFFFF, 9'h080, 32'h43000000, 1'b0, 32'h0, 4'd0};
        ev[5]  = '{32'h3F800000, 9'h000, 32'h00000000, 1'b1, 32'hFF800000, 4'd0};
        ev[6]  = '{32'h3F800000, 9'h000, 32'h00000000, 1'b1, 32'hFF800000, 4'd0};
        ev[7]  = '{32'h3F800000, 9'h000, 32'h00000000, 1'b1, 32'h7FC00000, 4'd0};
        ev[8]  = '{32'h3F800000, 9'h000, 32'h00000000, 1'b1, 32'h7FC00000, 4'd0};
        ev[9]  = '{32'h3F800000, 9'h000, 32'h00000000, 1'b1, 32'h7F800000, 4'd0};
        ev[10] = '{32'h3F800000, 9'h000, 32'h00000000, 1'b1, 32'h7FC00000, 4'd0};
        ev[11] = '{32'h3F400000, 9'h001, 32'h3F800000, 1'b0, 32'h0, 4'd0};
        ev[12] = '{32'h3F800000, 9'h181, 32'hC2FE0000, 1'b0, 32'h0, 4'd0};
        ev[13] = '{32'h3F400000, 9'h182, 32'hC2FC0000, 1'b0, 32'h0, 4'd0};
        for (int i = 0; i < 14; i++) ev[i].tag = 4'(i);
        while (got < 14 && cyc < 100) begin
            step(sent < 14, (sent < 14) ? xv[sent] : $urandom, 4'(sent), 1'b1, acc, ov, g);
            if (acc) sent++;
            if (ov) begin
                checks++;
                if (g !== ev[got]) begin
                    errors++;
                    $display("FAIL directed[%0d] x=%h: got mant=%h e=%h ef=%h sp=%b sv=%h tag=%h, expected mant=%h e=%h ef=%h sp=%b sv=%h tag=%h",
                             got, xv[got], g.mant, g.e, g.ef, g.sp, g.sv, g.tag,
                             ev[got].mant, ev[got].e, ev[got].ef, ev[got].sp, ev[got].sv, ev[got].tag);
                end
                got++;
            end
            cyc++;
        end
        checks++;
        if (got != 14) begin
            errors++;
            $display("FAIL directed_count: got %0d results, expected 14", got);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] xv [6];
        logic        acc, ov, ordy, stalled = 1'b0, saw_full = 1'b0;
        res_t        g, held = '0, ex;
        int          sent = 0, got = 0, cyc = 0;
        for (int i = 0; i < 6; i++) xv[i] = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        while (got < 6 && cyc < 60) begin
            ordy = !(cyc >= 3 && cyc <= 6);
            step(sent < 6, (sent < 6) ? xv[sent] : 32'd0, 4'(sent), ordy, acc, ov, g);
            if (sent < 6 && !acc) saw_full = 1'b1;
            if (acc) sent++;
            if (stalled) begin
                checks++;
                if (g !== held) begin
                    errors++;
                    $display("FAIL bp_hold cyc=%0d: got mant=%h tag=%h, expected held mant=%h tag=%h",
                             cyc, g.mant, g.tag, held.mant, held.tag);
                end
            end
            stalled = ov && !ordy;
            held = g;
            if (ov && ordy) begin
                ex = model(xv[got], 4'(got));
                checks++;
                if (g !== ex) begin
                    errors++;
                    $display("FAIL bp_result[%0d]: got mant=%h e=%h ef=%h tag=%h, expected mant=%h e=%h ef=%h tag=%h",
                             got, g.mant, g.e, g.ef, g.tag, ex.mant, ex.e, ex.ef, ex.tag);
                end
                got++;
            end
            cyc++;
        end
        checks++;
        if (!saw_full) begin
            errors++;
            $display("FAIL bp_in_ready: got in_ready never low, expected a drop while both stages full");
        end
        checks++;
        if (got != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d results, expected 6", got);
        end
    endtask

    task automatic test_throughput;
        logic [31:0] xv [100];
        logic        acc, ov;
        res_t        g, ex;
        real         mr;
        int          got = 0, bubbles = 0, stalls = 0;
        for (int i = 0; i < 100; i++) xv[i] = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        for (int k = 0; k < 102; k++) begin
            step(k < 100, (k < 100) ? xv[k] : $urandom, 4'(k), 1'b1, acc, ov, g);
            if (k < 100 && !acc) stalls++;
            if (k >= 2 && !ov) bubbles++;
            if (ov && got < 100) begin
                ex = model(xv[got], 4'(got));
                checks++;
                if (g !== ex) begin
                    errors++;
                    $display("FAIL tp_result[%0d] x=%h: got mant=%h e=%h ef=%h sp=%b tag=%h, expected mant=%h e=%h ef=%h sp=%b tag=%h",
                             got, xv[got], g.mant, g.e, g.ef, g.sp, g.tag,
                             ex.mant, ex.e, ex.ef, ex.sp, ex.tag);
                end
                mr = (1.0 + real'(g.mant[22:0]) / 8388608.0) * ((g.mant[30:23] == 8'd127) ? 1.0 : 0.5);
                mr = scale2(mr, int'($signed(g.e)));
                checks++;
                if (mr != xval(xv[got])) begin
                    errors++;
                    $display("FAIL tp_recon[%0d]: got m*2^e=%e, expected x=%e", got, mr, xval(xv[got]));
                end
                got++;
            end
        end
        checks++;
        if (stalls != 0 || bubbles != 0 || got != 100) begin
            errors++;
            $display("FAIL tp_rate: got stalls=%0d bubbles=%0d results=%0d, expected 0/0/100",
                     stalls, bubbles, got);
        end
    endtask

    task automatic test_reset_midstream;
        logic        acc, ov;
        res_t        g, ex;
        logic [31:0] xd;
        int          stale = 0;
        step(1'b1, 32'h40400000, 4'hA, 1'b1, acc, ov, g);
        step(1'b1, 32'h3F000000, 4'hB, 1'b0, acc, ov, g);
        rst = 1'b1;
        step(1'b1, 32'h3F800000, 4'hC, 1'b0, acc, ov, g);
        checks++;
        if (acc !== 1'b0) begin
            errors++;
            $display("FAIL rst_accept: got in_ready=1 during reset, expected 0");
        end
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_state: got valid/ready=%b%b, expected 00", out_valid, in_ready);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, $urandom, 4'($urandom), 1'b1, acc, ov, g);
            if (ov) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL rst_stale: got %0d stale results, expected 0", stale);
        end
        xd = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        ex = model(xd, 4'h7);
        step(1'b1, xd, 4'h7, 1'b1, acc, ov, g);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL rst_resume_accept: got accept=%b, expected 1", acc);
        end
        step(1'b0, 32'd0, 4'd0, 1'b1, acc, ov, g);
        checks++;
        if (ov !== 1'b0) begin
            errors++;
            $display("FAIL rst_latency_early: got out_valid=%b one cycle after accept, expected 0", ov);
        end
        step(1'b0, 32'd0, 4'd0, 1'b1, acc, ov, g);
        checks++;
        if (ov !== 1'b1 || g !== ex) begin
            errors++;
            $display("FAIL rst_resume_result: got valid=%b mant=%h e=%h tag=%h, expected valid=1 mant=%h e=%h tag=%h",
                     ov, g.mant, g.e, g.tag, ex.mant, ex.e, ex.tag);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_throughput();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
